// File: rtl/template.sv
// Streaming moving-average filter: mean of the last 2**WINDOW_LOG2 enabled samples, one-edge latency.
// Optional build macro TEMPLATE_ROUND_EN selects round-half-up instead of floor.
`timescale 1ns/1ps
module template #(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] input_data,
  input  logic                         enable,
  output logic signed [DATA_WIDTH-1:0] output_data,
  output logic                         output_data_valid
);

  localparam int W      = 1 << WINDOW_LOG2;
  localparam int SUM_W  = DATA_WIDTH + WINDOW_LOG2;
  localparam int FILL_W = WINDOW_LOG2 + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(W);

  function automatic logic signed [SUM_W-1:0] widen(input logic signed [DATA_WIDTH-1:0] x);
    return {{WINDOW_LOG2{x[DATA_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] scale(input logic signed [SUM_W-1:0] s);
`ifdef TEMPLATE_ROUND_EN
    logic signed [SUM_W:0] guarded;
    // Guard bit keeps the half-LSB add from wrapping at the positive limit.
    guarded = {s[SUM_W-1], s} + ((SUM_W+1)'(1) << (WINDOW_LOG2-1));
    guarded = guarded >>> WINDOW_LOG2;
    return guarded[DATA_WIDTH-1:0];
`else
    logic signed [SUM_W-1:0] shifted;
    shifted = s >>> WINDOW_LOG2;
    return shifted[DATA_WIDTH-1:0];
`endif
  endfunction

  logic signed [DATA_WIDTH-1:0] taps [W];
  logic signed [DATA_WIDTH-1:0] oldest;
  logic signed [SUM_W-1:0]      sum;
  logic signed [SUM_W-1:0]      sum_next;
  logic [FILL_W-1:0]            fill;
  logic [FILL_W-1:0]            fill_next;

  always_comb begin
    oldest    = (fill == FULL) ? taps[W-1] : '0;
    sum_next  = sum + widen(input_data) - widen(oldest);
    fill_next = (fill == FULL) ? FULL : fill + FILL_W'(1);
  end

  // Stage p0: window update and registered mean
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < W; i++) taps[i] <= '0;
      sum               <= '0;
      fill              <= '0;
      output_data       <= '0;
      output_data_valid <= 1'b0;
    end else if (enable) begin
      taps[0] <= input_data;
      for (int i = 1; i < W; i++) taps[i] <= taps[i-1];
      sum               <= sum_next;
      fill              <= fill_next;
      output_data       <= scale(sum_next);
      output_data_valid <= (fill_next == FULL);
    end else begin
      output_data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_template.sv
// Directed plus randomized bench for the moving-average filter; expected results flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_template;

  logic               clk;
  logic               reset;
  logic signed [15:0] input_data;
  logic               enable;
  logic signed [15:0] output_data;
  logic               output_data_valid;

  int total;
  int bad;

  typedef struct {
    logic [15:0] d;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   win[$];
  logic [15:0] last_out;

  template #(.DATA_WIDTH(16), .WINDOW_LOG2(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .input_data       (input_data),
    .enable           (enable),
    .output_data      (output_data),
    .output_data_valid(output_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    sb.delete();
    last_out = 16'h0000;
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare after the edge.
  task automatic drive(input logic en, input int d, input string tag);
    exp_t e;
    exp_t got;
    int   s;
    enable     = en;
    input_data = 16'(d);
    if (en) begin
      win.push_back(d);
      if (win.size() > 4) void'(win.pop_front());
      s = 0;
      foreach (win[i]) s += win[i];
`ifdef TEMPLATE_ROUND_EN
      e.d = 16'((s + 2) >>> 2);
`else
      e.d = 16'(s >>> 2);
`endif
      e.v = (win.size() == 4);
      last_out = e.d;
    end else begin
      e.d = last_out;
      e.v = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    enable = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
    end else begin
      got = sb.pop_front();
      chk({tag, "_data"}, output_data, got.d);
      chk({tag, "_valid"}, {15'b0, output_data_valid}, {15'b0, got.v});
    end
  endtask

  initial begin
    logic [15:0] exp5;
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    input_data = '0;
    last_out   = 16'h0000;

    // Reset held with enable toggling: outputs stay cleared
    for (int i = 0; i < 4; i++) begin
      enable     = i[0];
      input_data = 16'(i * 7 + 3);
      @(posedge clk);
      #1;
      chk("rst_hold_data", output_data, 16'h0000);
      chk("rst_hold_valid", {15'b0, output_data_valid}, 16'h0000);
    end
    reset = 1'b0;
    enable = 1'b0;
    model_reset();

    drive(1'b1, 4, "fill1");
    drive(1'b1, 8, "fill2");
    drive(1'b1, 12, "fill3");
    drive(1'b1, 16, "fill4");
    chk("first_mean", output_data, 16'd10);
    chk("first_valid", {15'b0, output_data_valid}, 16'h0001);

    drive(1'b1, 20, "slide");
    chk("slide_mean", output_data, 16'd14);

    for (int i = 0; i < 3; i++) drive(1'b0, 0, "gap");
    chk("gap_hold", output_data, 16'd14);
    drive(1'b1, 24, "after_gap");
    chk("after_gap_mean", output_data, 16'd18);
    chk("after_gap_valid", {15'b0, output_data_valid}, 16'h0001);

    // Async reset between edges clears outputs without a clock edge
    #2 reset = 1'b1;
    #1;
    chk("async_rst_data", output_data, 16'h0000);
    chk("async_rst_valid", {15'b0, output_data_valid}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    drive(1'b1, -1, "neg1");
    drive(1'b1, -1, "neg2");
    drive(1'b1, -1, "neg3");
    drive(1'b1, -2, "neg4");
`ifdef TEMPLATE_ROUND_EN
    exp5 = 16'hFFFF;
`else
    exp5 = 16'hFFFE;
`endif
    chk("neg_mean", output_data, exp5);
    chk("neg_valid", {15'b0, output_data_valid}, 16'h0001);

    drive(1'b1, 5, "more1");
    drive(1'b1, 6, "more2");
    drive(1'b1, 7, "more3");
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_data", output_data, 16'h0000);
    reset = 1'b0;
    model_reset();
    drive(1'b1, 100, "refill1");
    drive(1'b1, 100, "refill2");
    drive(1'b1, 100, "refill3");
    chk("refill3_valid", {15'b0, output_data_valid}, 16'h0000);
    drive(1'b1, 100, "refill4");
    chk("refill_mean", output_data, 16'd100);
    chk("refill_valid", {15'b0, output_data_valid}, 16'h0001);

    // Extremes: full-scale window must not overflow
    for (int i = 0; i < 4; i++) drive(1'b1, 32767, "max");
    chk("max_mean", output_data, 16'h7FFF);
    for (int i = 0; i < 4; i++) drive(1'b1, -32768, "min");
    chk("min_mean", output_data, 16'h8000);

    for (int i = 0; i < 32; i++)
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
